// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, flag bundle and arbiter state shared by the ALU arbiter slice
package alu_pkg;
    localparam int ALU_OP_W = 3;
    localparam logic [ALU_OP_W-1:0] OP_ADD = 3'd0;
    localparam logic [ALU_OP_W-1:0] OP_SUB = 3'd1;
    localparam logic [ALU_OP_W-1:0] OP_NOT = 3'd2;
    localparam logic [ALU_OP_W-1:0] OP_AND = 3'd3;
    localparam logic [ALU_OP_W-1:0] OP_OR  = 3'd4;
    localparam logic [ALU_OP_W-1:0] OP_XOR = 3'd5;
    localparam logic [ALU_OP_W-1:0] OP_SLT = 3'd6;
    localparam logic [ALU_OP_W-1:0] OP_EQ  = 3'd7;
    typedef struct packed {
        logic carry;
        logic overflow;
        logic zero;
    } alu_flags_t;
    typedef enum logic {PRI0, PRI1} arb_state_t;
endpackage

// File: rtl/alu_arb_ctrl_if.sv
// alu_arb_ctrl_if: two-requester command ports plus the single response port
interface alu_arb_ctrl_if import alu_pkg::*; #(parameter int WIDTH = 4);
    logic [1:0] req_valid;
    logic [1:0] req_ready;
    logic [1:0] req_chain;
    logic [1:0][ALU_OP_W-1:0] req_op;
    logic [1:0][WIDTH-1:0] req_a;
    logic [1:0][WIDTH-1:0] req_b;
    logic rsp_valid;
    logic rsp_ready;
    logic rsp_id;
    logic [WIDTH-1:0] rsp_result;
    logic rsp_carry;
    logic rsp_overflow;
    logic rsp_zero;
    modport master(
        output req_valid, req_chain, req_op, req_a, req_b, rsp_ready,
        input req_ready, rsp_valid, rsp_id, rsp_result, rsp_carry, rsp_overflow, rsp_zero
    );
    modport slave(
        input req_valid, req_chain, req_op, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_result, rsp_carry, rsp_overflow, rsp_zero
    );
endinterface

// File: rtl/alu_core.sv
// alu_core: combinational WIDTH-bit ALU with carry/borrow, signed overflow and zero flags
module alu_core import alu_pkg::*; #(
    parameter int WIDTH = 4
) (
    input  logic [ALU_OP_W-1:0] op,
    input  logic [WIDTH-1:0]    a,
    input  logic [WIDTH-1:0]    b,
    output logic [WIDTH-1:0]    result,
    output logic                carry,
    output logic                overflow,
    output logic                zero
);
    localparam int M = WIDTH - 1;
    logic [WIDTH:0] sum, dif;
    assign sum = {1'b0, a} + {1'b0, b};
    // the extra top bit of the widened difference is the unsigned borrow
    assign dif = {1'b0, a} - {1'b0, b};
    always_comb begin
        result = '0;
        carry = 1'b0;
        overflow = 1'b0;
        case (op)
            OP_ADD: begin
                result = sum[M:0];
                carry = sum[WIDTH];
                overflow = (a[M] == b[M]) && (sum[M] != a[M]);
            end
            OP_SUB: begin
                result = dif[M:0];
                carry = dif[WIDTH];
                overflow = (a[M] != b[M]) && (dif[M] != a[M]);
            end
            OP_NOT: result = ~a;
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            OP_SLT: result = WIDTH'($signed(a) < $signed(b));
            OP_EQ:  result = WIDTH'(a == b);
            default: result = '0;
        endcase
    end
    assign zero = result == '0;
endmodule

// File: rtl/alu_arb_ctrl.sv
// alu_arb_ctrl: round-robin sharing of one ALU between two requesters with a registered response buffer
module alu_arb_ctrl import alu_pkg::*; #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_arb_ctrl_if.slave    bus,
    output logic [CNT_W-1:0] ops_done
);
    arb_state_t state_q, state_d;
    logic ptr, gnt, acc, can_accept, vld_q, id_q;
    logic [WIDTH-1:0] a_eff, alu_res, res_q;
    alu_flags_t alu_flg, flg_q;
    assign ptr = state_q == PRI1;
    assign can_accept = !vld_q || bus.rsp_ready;
    assign gnt = bus.req_valid[ptr] ? ptr : !ptr;
    assign acc = can_accept && |bus.req_valid;
    // chained ops reuse the held result even after it has been drained
    assign a_eff = bus.req_chain[gnt] ? res_q : bus.req_a[gnt];
    always_comb begin
        bus.req_ready = acc ? {gnt, !gnt} : 2'b00;
        state_d = acc ? (gnt ? PRI0 : PRI1) : state_q;
    end
    alu_core #(.WIDTH(WIDTH)) u_core (
        .op(bus.req_op[gnt]),
        .a(a_eff),
        .b(bus.req_b[gnt]),
        .result(alu_res),
        .carry(alu_flg.carry),
        .overflow(alu_flg.overflow),
        .zero(alu_flg.zero)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= PRI0;
            vld_q <= 1'b0;
            id_q <= 1'b0;
            res_q <= '0;
            flg_q <= '0;
            ops_done <= '0;
        end else begin
            state_q <= state_d;
            if (acc) begin
                vld_q <= 1'b1;
                id_q <= gnt;
                res_q <= alu_res;
                flg_q <= alu_flg;
            end else if (bus.rsp_ready) begin
                vld_q <= 1'b0;
            end
            if (vld_q && bus.rsp_ready) ops_done <= ops_done + CNT_W'(1);
        end
    end
    assign bus.rsp_valid = vld_q;
    assign bus.rsp_id = id_q;
    assign bus.rsp_result = res_q;
    assign bus.rsp_carry = flg_q.carry;
    assign bus.rsp_overflow = flg_q.overflow;
    assign bus.rsp_zero = flg_q.zero;
endmodule

// File: tb/tb_alu_arb_ctrl.sv
// tb_alu_arb_ctrl: vector table, directed corner sequences and a randomized run against an abstract model
module tb_alu_arb_ctrl;
    import alu_pkg::*;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [7:0] ops_done;
    int total = 0;
    int bad = 0;
    alu_arb_ctrl_if #(.WIDTH(4)) bus();
    alu_arb_ctrl #(.WIDTH(4), .CNT_W(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus), .ops_done(ops_done));
    always #5 clk = ~clk;

    typedef struct {int rq; int op; int a; int b; int exp;} vec_t;
    vec_t vec[14];

    task automatic chk(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(int r, int op, int a, int b, bit ch);
        bus.req_valid[r] = 1'b1;
        bus.req_op[r] = 3'(op);
        bus.req_a[r] = 4'(a);
        bus.req_b[r] = 4'(b);
        bus.req_chain[r] = ch;
    endtask

    // packed view {valid, id, result[3:0], carry, overflow, zero}
    function automatic int rsp();
        return int'({bus.rsp_valid, bus.rsp_id, bus.rsp_result, bus.rsp_carry, bus.rsp_overflow, bus.rsp_zero});
    endfunction

    // reference ALU from plain integer arithmetic; returns {result, carry, overflow, zero}
    function automatic int alu_ref(int op, int a, int b);
        int sa, sb, r;
        bit c, v;
        sa = a > 7 ? a - 16 : a;
        sb = b > 7 ? b - 16 : b;
        r = 0;
        c = 1'b0;
        v = 1'b0;
        case (op)
            0: begin r = a + b; c = r > 15; v = (sa + sb > 7) || (sa + sb < -8); end
            1: begin r = a - b; c = a < b; v = (sa - sb > 7) || (sa - sb < -8); end
            2: r = ~a;
            3: r = a & b;
            4: r = a | b;
            5: r = a ^ b;
            6: r = int'(sa < sb);
            default: r = int'(a == b);
        endcase
        r = r & 15;
        return r * 8 + int'(c) * 4 + int'(v) * 2 + int'(r == 0);
    endfunction

    bit p[2];
    bit pch[2];
    int pop[2], pa[2], pb[2];
    bit m_fav, m_vld, m_id, rdy, can, g, acc;
    int m_out, m_done;

    initial begin
        vec = '{'{0, 0, 7, 1, 7'b1000010}, '{1, 1, 3, 5, 7'b1110100}, '{0, 0, 15, 1, 7'b0000101},
                '{1, 1, 8, 1, 7'b0111010}, '{0, 2, 5, 0, 7'b1010000}, '{1, 3, 12, 10, 7'b1000000},
                '{0, 4, 12, 3, 7'b1111000}, '{1, 5, 9, 9, 7'b0000001}, '{0, 6, 8, 7, 7'b0001000},
                '{1, 6, 7, 8, 7'b0000001}, '{0, 7, 6, 6, 7'b0001000}, '{1, 7, 6, 7, 7'b0000001},
                '{0, 1, 5, 5, 7'b0000001}, '{1, 0, 4, 4, 7'b1000010}};
        bus.req_valid = 2'b00;
        bus.req_chain = 2'b00;
        bus.req_op = '0;
        bus.req_a = '0;
        bus.req_b = '0;
        bus.rsp_ready = 1'b1;
        step();
        step();
        chk("reset_rsp", rsp(), 0);
        chk("reset_done", ops_done, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 14; i++) begin
            bus.req_valid = 2'b00;
            drive(vec[i].rq, vec[i].op, vec[i].a, vec[i].b, 1'b0);
            step();
            chk("vec", rsp(), 256 + vec[i].rq * 128 + vec[i].exp);
        end
        bus.req_valid = 2'b00;
        step();
        chk("drain_valid", bus.rsp_valid, 0);
        chk("drain_hold", bus.rsp_result, 8);
        chk("done_table", ops_done, 14);
        drive(0, 0, 3, 0, 1'b0);
        drive(1, 0, 12, 0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("cont_ready", bus.req_ready, i % 2 == 1 ? 2 : 1);
            step();
            chk("cont_id", bus.rsp_id, i % 2);
            chk("cont_res", bus.rsp_result, i % 2 == 1 ? 12 : 3);
        end
        bus.req_valid = 2'b00;
        step();
        chk("done_cont", ops_done, 18);
        drive(0, 0, 1, 1, 1'b0);
        bus.rsp_ready = 1'b0;
        step();
        chk("bp_first", rsp(), 272);
        drive(0, 1, 9, 2, 1'b0);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp_ready", bus.req_ready, 0);
            step();
            chk("bp_hold", rsp(), 272);
        end
        bus.rsp_ready = 1'b1;
        #1;
        chk("bp_accept", bus.req_ready, 1);
        step();
        chk("bp_result", rsp(), 314);
        bus.req_valid = 2'b00;
        step();
        chk("done_bp", ops_done, 20);
        drive(0, 0, 2, 3, 1'b0);
        step();
        chk("chain_seed", bus.rsp_result, 5);
        bus.req_valid = 2'b00;
        drive(1, 0, 15, 4, 1'b1);
        step();
        chk("chain_add", rsp(), 458);
        drive(1, 1, 0, 9, 1'b1);
        step();
        chk("chain_sub", rsp(), 385);
        bus.req_valid = 2'b00;
        bus.req_chain = 2'b00;
        step();
        chk("done_chain", ops_done, 23);
        drive(0, 0, 1, 2, 1'b0);
        bus.rsp_ready = 1'b0;
        step();
        chk("rst_pre", bus.rsp_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_async", rsp(), 0);
        chk("rst_done", ops_done, 0);
        step();
        rst_n = 1'b1;
        drive(0, 0, 1, 1, 1'b0);
        drive(1, 0, 2, 2, 1'b0);
        bus.rsp_ready = 1'b1;
        #1;
        chk("rst_ptr", bus.req_ready, 1);
        step();
        chk("rst_grant", rsp(), 272);
        chk("rst_nocount", ops_done, 0);
        bus.req_valid = 2'b00;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        p = '{0, 0};
        m_fav = 1'b0;
        m_vld = 1'b0;
        m_id = 1'b0;
        m_out = 0;
        m_done = 0;
        for (int n = 0; n < 400; n++) begin
            for (int r = 0; r < 2; r++) begin
                if (!p[r] && $urandom_range(0, 2) != 0) begin
                    p[r] = 1'b1;
                    pop[r] = int'($urandom_range(0, 7));
                    pa[r] = int'($urandom_range(0, 15));
                    pb[r] = int'($urandom_range(0, 15));
                    pch[r] = $urandom_range(0, 3) == 0;
                end
                bus.req_valid[r] = p[r];
                bus.req_op[r] = 3'(pop[r]);
                bus.req_a[r] = 4'(pa[r]);
                bus.req_b[r] = 4'(pb[r]);
                bus.req_chain[r] = pch[r];
            end
            rdy = $urandom_range(0, 3) != 0;
            bus.rsp_ready = rdy;
            #1;
            can = !m_vld || rdy;
            g = p[m_fav] ? m_fav : !m_fav;
            acc = can && (p[0] || p[1]);
            chk("rnd_ready", bus.req_ready, acc ? (g ? 2 : 1) : 0);
            step();
            if (m_vld && rdy) m_done = (m_done + 1) % 256;
            if (acc) begin
                m_out = alu_ref(pop[g], pch[g] ? m_out / 8 : pa[g], pb[g]);
                m_vld = 1'b1;
                m_id = g;
                p[g] = 1'b0;
                m_fav = !g;
            end else if (rdy) begin
                m_vld = 1'b0;
            end
            chk("rnd_rsp", rsp(), int'(m_vld) * 256 + int'(m_id) * 128 + m_out);
            chk("rnd_done", ops_done, m_done);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
